// File: rtl/iic_pkg.sv
// Shared types, widths and the address-decode helper for the IIC slave receiver.
// State encoding is fixed here so that checkers and debug views share one definition.
package iic_pkg;

    localparam int IIC_ADDR_W = 7;
    localparam int IIC_BYTE_W = 8;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = IDLE,
        S_ADDR     = ADDR,
        S_ADDR_ACK = ADDR_ACK,
        S_DATA     = DATA,
        S_DATA_ACK = DATA_ACK,
        S_IGNORE   = IGNORE
    } iic_state_e;

    localparam logic [IIC_ADDR_W-1:0] GENERAL_CALL_ADDR = 7'h00;

    // Only write transfers can match; a read request is always NACKed.
    function automatic logic addr_match(
        input logic [IIC_BYTE_W-1:0] addr_byte,
        input logic [IIC_ADDR_W-1:0] slave_addr,
        input logic                  gc_en
    );
        logic is_write;
        logic own_hit;
        logic gc_hit;
        is_write = (addr_byte[0] == 1'b0);
        own_hit  = (addr_byte[IIC_BYTE_W-1:1] == slave_addr);
        gc_hit   = gc_en & (addr_byte[IIC_BYTE_W-1:1] == GENERAL_CALL_ADDR);
        return is_write & (own_hit | gc_hit);
    endfunction

endpackage

// File: rtl/iic_slave_rx_if.sv
// Line-level inputs from the SCL/SDA edge detectors and the receiver's outputs,
// bundled so that the receiver and its environment connect through one port.
interface iic_slave_rx_if;
    import iic_pkg::*;

    logic                  SclLevel;
    logic                  SdaLevel;
    logic                  SclPos;
    logic                  SclNeg;
    logic                  SdaPos;
    logic                  SdaNeg;
    logic                  SdaOe;
    logic [IIC_BYTE_W-1:0] RxData;
    logic                  RxValid;
    logic                  RxFirst;
    logic                  BusBusy;
    logic                  AddrMatch;

    modport slave (
        input  SclLevel, SdaLevel, SclPos, SclNeg, SdaPos, SdaNeg,
        output SdaOe, RxData, RxValid, RxFirst, BusBusy, AddrMatch
    );

    modport master (
        output SclLevel, SdaLevel, SclPos, SclNeg, SdaPos, SdaNeg,
        input  SdaOe, RxData, RxValid, RxFirst, BusBusy, AddrMatch
    );

endinterface

// File: rtl/iic_cond_detect.sv
// Combinational START/STOP decode. An SDA edge that coincides with an SCL rising
// pulse belongs to a bit sample, so it is excluded from condition detection.
module iic_cond_detect (
    input  logic i_scl_level,
    input  logic i_scl_pos,
    input  logic i_sda_pos,
    input  logic i_sda_neg,
    output logic o_start,
    output logic o_stop
);

    assign o_start = i_sda_neg & i_scl_level & ~i_scl_pos;
    assign o_stop  = i_sda_pos & i_scl_level & ~i_scl_pos;

endmodule

// File: rtl/iic_slave_rx.sv
// Write-only IIC slave receiver: address match, byte shift-in, ACK drive, byte strobes.
// Build option IIC_GENERAL_CALL_EN: also accept the general-call address (8'h00).
module iic_slave_rx
    import iic_pkg::*;
#(
    parameter logic [IIC_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input  logic         CLK,
    input  logic         RSTn,
    iic_slave_rx_if.slave bus
);

`ifdef IIC_GENERAL_CALL_EN
    localparam logic GC_EN = 1'b1;
`else
    localparam logic GC_EN = 1'b0;
`endif

    logic                  w_start;
    logic                  w_stop;
    logic [IIC_BYTE_W-1:0] w_shift_next;

    iic_state_e            r_state;
    logic [IIC_BYTE_W-1:0] r_shift;
    logic [2:0]            r_cnt;
    logic                  r_byte_done;
    logic                  r_match;
    logic                  r_first_pend;
    logic                  r_sda_oe;
    logic [IIC_BYTE_W-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_rx_first;
    logic                  r_bus_busy;
    logic                  r_addr_match;

    iic_cond_detect u_cond_detect (
        .i_scl_level (bus.SclLevel),
        .i_scl_pos   (bus.SclPos),
        .i_sda_pos   (bus.SdaPos),
        .i_sda_neg   (bus.SdaNeg),
        .o_start     (w_start),
        .o_stop      (w_stop)
    );

    assign w_shift_next = {r_shift[IIC_BYTE_W-2:0], bus.SdaLevel};

    // Protocol FSM with shift register, bit counter and all registered outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= S_IDLE;
            r_shift      <= 8'h00;
            r_cnt        <= 3'd0;
            r_byte_done  <= 1'b0;
            r_match      <= 1'b0;
            r_first_pend <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_rx_first   <= 1'b0;
            r_bus_busy   <= 1'b0;
            r_addr_match <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            if (w_start) begin
                r_state      <= S_ADDR;
                r_cnt        <= 3'd0;
                r_byte_done  <= 1'b0;
                r_match      <= 1'b0;
                r_first_pend <= 1'b0;
                r_sda_oe     <= 1'b0;
                r_bus_busy   <= 1'b1;
                r_addr_match <= 1'b0;
            end else if (w_stop) begin
                // Any partially shifted byte is simply dropped here.
                r_state      <= S_IDLE;
                r_cnt        <= 3'd0;
                r_byte_done  <= 1'b0;
                r_match      <= 1'b0;
                r_first_pend <= 1'b0;
                r_sda_oe     <= 1'b0;
                r_bus_busy   <= 1'b0;
                r_addr_match <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_sda_oe <= 1'b0;
                    end
                    S_ADDR: begin
                        if (bus.SclPos) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_byte_done <= 1'b1;
                                r_match     <= addr_match(w_shift_next, SLAVE_ADDR, GC_EN);
                            end
                        end else if (bus.SclNeg && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            if (r_match) begin
                                r_state      <= S_ADDR_ACK;
                                r_sda_oe     <= 1'b1;
                                r_addr_match <= 1'b1;
                                r_first_pend <= 1'b1;
                            end else begin
                                r_state  <= S_IGNORE;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK, S_DATA_ACK: begin
                        // ACK is held low through the whole ninth SCL high phase.
                        if (bus.SclNeg) begin
                            r_sda_oe    <= 1'b0;
                            r_state     <= S_DATA;
                            r_cnt       <= 3'd0;
                            r_byte_done <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        if (bus.SclPos) begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + 3'd1;
                            if (r_cnt == 3'd7) begin
                                r_byte_done <= 1'b1;
                            end
                        end else if (bus.SclNeg && r_byte_done) begin
                            r_byte_done  <= 1'b0;
                            r_rx_data    <= r_shift;
                            r_rx_valid   <= 1'b1;
                            r_rx_first   <= r_first_pend;
                            r_first_pend <= 1'b0;
                            r_sda_oe     <= 1'b1;
                            r_state      <= S_DATA_ACK;
                        end
                    end
                    S_IGNORE: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.SdaOe     = r_sda_oe;
    assign bus.RxData    = r_rx_data;
    assign bus.RxValid   = r_rx_valid;
    assign bus.RxFirst   = r_rx_first;
    assign bus.BusBusy   = r_bus_busy;
    assign bus.AddrMatch = r_addr_match;

endmodule

// File: tb/tb_iic_slave_rx.sv
// Self-checking bench for iic_slave_rx: drives edge pulses and line levels directly,
// scoreboards received bytes and checks ACK timing, bus flags and reset behaviour.
module tb_iic_slave_rx;
    import iic_pkg::*;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    always #5 CLK = ~CLK;

    iic_slave_rx_if bus ();

    iic_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    logic       prev_valid = 1'b0;

`ifdef IIC_GENERAL_CALL_EN
    localparam logic GC_ON = 1'b1;
`else
    localparam logic GC_ON = 1'b0;
`endif

    // ACK observation vector: {before last fall, after last fall, ACK SCL high, after ACK fall}
    localparam logic [3:0] OBS_ACK  = 4'b0110;
    localparam logic [3:0] OBS_NACK = 4'b0000;

    // Monitor: every strobe must match the oldest expected {first, data} and last one cycle.
    always @(negedge CLK) begin
        if (bus.RxValid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got RxValid data=%h first=%b, required no strobe",
                         bus.RxData, bus.RxFirst);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.RxFirst, bus.RxData} !== mon_exp) begin
                    errors++;
                    $display("FAIL rx_byte: got first=%b data=%h, required first=%b data=%h",
                             bus.RxFirst, bus.RxData, mon_exp[8], mon_exp[7:0]);
                end
            end
            checks++;
            if (prev_valid !== 1'b0) begin
                errors++;
                $display("FAIL rx_strobe_width: RxValid high in consecutive cycles, required 1 cycle");
            end
        end
        prev_valid = bus.RxValid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_scl(input logic v);
        @(negedge CLK);
        if (bus.SclLevel !== v) begin
            bus.SclLevel = v;
            bus.SclPos   = v;
            bus.SclNeg   = ~v;
        end
        @(negedge CLK);
        bus.SclPos = 1'b0;
        bus.SclNeg = 1'b0;
    endtask

    task automatic drive_sda(input logic v);
        @(negedge CLK);
        if (bus.SdaLevel !== v) begin
            bus.SdaLevel = v;
            bus.SdaPos   = v;
            bus.SdaNeg   = ~v;
        end
        @(negedge CLK);
        bus.SdaPos = 1'b0;
        bus.SdaNeg = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        drive_sda(b);
        drive_scl(1'b1);
        drive_scl(1'b0);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i >= 8 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [3:0] obs);
        send_bits(b, 7);
        drive_sda(b[0]);
        drive_scl(1'b1);
        obs[3] = bus.SdaOe;
        drive_scl(1'b0);
        obs[2] = bus.SdaOe;
        drive_sda(1'b1);
        drive_scl(1'b1);
        obs[1] = bus.SdaOe;
        drive_scl(1'b0);
        obs[0] = bus.SdaOe;
    endtask

    task automatic send_start();
        drive_sda(1'b1);
        drive_scl(1'b1);
        drive_sda(1'b0);
        drive_scl(1'b0);
    endtask

    task automatic send_stop();
        drive_sda(1'b0);
        drive_scl(1'b1);
        drive_sda(1'b1);
    endtask

    task automatic test_reset();
        bus.SclLevel = 1'b1; bus.SdaLevel = 1'b1;
        bus.SclPos = 1'b0; bus.SclNeg = 1'b0; bus.SdaPos = 1'b0; bus.SdaNeg = 1'b0;
        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.SdaOe, bus.RxData, bus.RxValid, bus.RxFirst, bus.BusBusy, bus.AddrMatch} !== 13'h0) begin
            errors++;
            $display("FAIL reset_values: got oe=%b data=%h v=%b f=%b busy=%b match=%b, required all 0",
                     bus.SdaOe, bus.RxData, bus.RxValid, bus.RxFirst, bus.BusBusy, bus.AddrMatch);
        end
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.SdaOe, bus.BusBusy, bus.AddrMatch} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got oe/busy/match=%b, required 000",
                     {bus.SdaOe, bus.BusBusy, bus.AddrMatch});
        end
    endtask

    task automatic test_basic_write();
        logic [3:0] obs;
        send_start();
        checks++;
        if (bus.BusBusy !== 1'b1) begin
            errors++; $display("FAIL basic_busy_start: got %b, required 1", bus.BusBusy);
        end
        send_byte(8'hA0, obs);
        checks++;
        if (obs !== OBS_ACK) begin
            errors++; $display("FAIL basic_addr_ack: got %b, required %b", obs, OBS_ACK);
        end
        checks++;
        if (bus.AddrMatch !== 1'b1) begin
            errors++; $display("FAIL basic_addr_match: got %b, required 1", bus.AddrMatch);
        end
        exp_q.push_back({1'b1, 8'hA5});
        send_byte(8'hA5, obs);
        checks++;
        if (obs !== OBS_ACK) begin
            errors++; $display("FAIL basic_data_ack: got %b, required %b", obs, OBS_ACK);
        end
        send_stop();
        checks++;
        if ({bus.BusBusy, bus.AddrMatch, bus.RxData} !== {2'b00, 8'hA5}) begin
            errors++;
            $display("FAIL basic_stop: got busy=%b match=%b data=%h, required 0 0 a5",
                     bus.BusBusy, bus.AddrMatch, bus.RxData);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL basic_rx_count: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_nack(input logic [7:0] addr_byte, input string name);
        logic [3:0] obs;
        send_start();
        send_byte(addr_byte, obs);
        checks++;
        if (obs !== OBS_NACK) begin
            errors++; $display("FAIL %s_addr_nack: got %b, required %b", name, obs, OBS_NACK);
        end
        send_byte(8'h5A, obs);
        checks++;
        if ({obs, bus.AddrMatch, bus.BusBusy} !== {OBS_NACK, 2'b01}) begin
            errors++;
            $display("FAIL %s_ignore: got obs=%b match=%b busy=%b, required 0000 0 1",
                     name, obs, bus.AddrMatch, bus.BusBusy);
        end
        send_stop();
        checks++;
        if (bus.BusBusy !== 1'b0) begin
            errors++; $display("FAIL %s_stop: got busy=%b, required 0", name, bus.BusBusy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        logic [3:0] obs2;
        logic [3:0] obs3;
        send_start();
        send_byte(8'hA0, obs);
        exp_q.push_back({1'b1, 8'h3C});
        send_byte(8'h3C, obs2);
        exp_q.push_back({1'b0, 8'h7E});
        send_byte(8'h7E, obs3);
        checks++;
        if ({obs, obs2, obs3} !== {OBS_ACK, OBS_ACK, OBS_ACK}) begin
            errors++; $display("FAIL b2b_acks: got %b %b %b, required all %b", obs, obs2, obs3, OBS_ACK);
        end
        send_bits(8'hF0, 4);
        send_stop();
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.BusBusy, bus.AddrMatch, bus.SdaOe, bus.RxData} !== {3'b000, 8'h7E}) begin
            errors++;
            $display("FAIL b2b_partial_stop: got busy=%b match=%b oe=%b data=%h, required 0 0 0 7e",
                     bus.BusBusy, bus.AddrMatch, bus.SdaOe, bus.RxData);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_rx_count: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_repeated_start();
        logic [3:0] obs;
        send_start();
        send_byte(8'hA0, obs);
        send_bits(8'hE0, 3);
        send_start();
        checks++;
        if ({bus.BusBusy, bus.AddrMatch, bus.SdaOe} !== 3'b100) begin
            errors++;
            $display("FAIL rstart_flags: got busy/match/oe=%b, required 100",
                     {bus.BusBusy, bus.AddrMatch, bus.SdaOe});
        end
        send_byte(8'hA0, obs);
        exp_q.push_back({1'b1, 8'h11});
        send_byte(8'h11, obs);
        checks++;
        if (obs !== OBS_ACK) begin
            errors++; $display("FAIL rstart_data_ack: got %b, required %b", obs, OBS_ACK);
        end
        send_stop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rstart_rx_count: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_during_ack();
        send_start();
        send_bits(8'hA0, 8);
        checks++;
        if (bus.SdaOe !== 1'b1) begin
            errors++; $display("FAIL rst_ack_setup: got SdaOe=%b, required 1", bus.SdaOe);
        end
        #2;
        RSTn = 1'b0;
        #1;
        checks++;
        if ({bus.SdaOe, bus.RxData, bus.RxValid, bus.RxFirst, bus.BusBusy, bus.AddrMatch} !== 13'h0) begin
            errors++;
            $display("FAIL rst_async_clear: got oe=%b data=%h v=%b f=%b busy=%b match=%b, required all 0",
                     bus.SdaOe, bus.RxData, bus.RxValid, bus.RxFirst, bus.BusBusy, bus.AddrMatch);
        end
        @(negedge CLK);
        bus.SclLevel = 1'b1;
        bus.SdaLevel = 1'b1;
        RSTn = 1'b1;
        send_bit(1'b1);
        drive_scl(1'b1);
        checks++;
        if ({bus.SdaOe, bus.BusBusy, bus.AddrMatch} !== 3'b000) begin
            errors++;
            $display("FAIL rst_wait_idle: got oe/busy/match=%b, required 000",
                     {bus.SdaOe, bus.BusBusy, bus.AddrMatch});
        end
    endtask

    task automatic test_general_call();
        logic [3:0] obs;
        logic [3:0] obs2;
        send_start();
        send_byte(8'h00, obs);
        if (GC_ON) exp_q.push_back({1'b1, 8'h06});
        send_byte(8'h06, obs2);
        checks++;
        if ({obs, obs2} !== (GC_ON ? {OBS_ACK, OBS_ACK} : {OBS_NACK, OBS_NACK})) begin
            errors++;
            $display("FAIL gcall_ack: got %b %b, required gc_en=%b acks", obs, obs2, GC_ON);
        end
        send_stop();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL gcall_rx_count: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_nack(8'hA2, "wrong_addr");
        test_nack(8'hA1, "read");
        test_back_to_back();
        test_repeated_start();
        test_reset_during_ack();
        test_general_call();
        repeat (4) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_slave_rx.md
# iic_slave_rx

Write-only IIC slave receiver that sits directly downstream of the SCL/SDA edge detectors. It consumes one-cycle edge pulses and registered line levels, then decodes START, STOP and repeated START. It matches a 7-bit slave address, shifts in data bytes and drives the ACK bit via an open-drain enable. Received bytes go to the register-file logic as single-cycle valid strobes.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit slave address acknowledged on write.
- CLK  in  1  system clock; all logic on posedge.
- RSTn  in  1  asynchronous, active-low reset.
- SclLevel  in  1  registered SCL level, same alignment as edge pulses.
- SdaLevel  in  1  registered SDA level, same alignment as edge pulses.
- SclPos  in  1  one-cycle SCL rising pulse.
- SclNeg  in  1  one-cycle SCL falling pulse.
- SdaPos  in  1  one-cycle SDA rising pulse.
- SdaNeg  in  1  one-cycle SDA falling pulse.
- SdaOe  out  1  1 = pull SDA low (ACK); 0 = release.
- RxData  out  8  last completed data byte.
- RxValid  out  1  one-cycle strobe: RxData updated.
- RxFirst  out  1  qualifies RxValid: first data byte after address.
- BusBusy  out  1  1 between START and STOP.
- AddrMatch  out  1  1 from address ACK until STOP/START.

## Operation
- Conditions are evaluated before bit logic and have priority over it.
  - START: SdaNeg & SclLevel & !SclPos.
  - STOP: SdaPos & SclLevel & !SclPos.
  - SclPos coinciding with an SDA edge is a bit sample, not a condition.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- START from any state: go to ADDR, clear bit counter and AddrMatch, set BusBusy, release SdaOe.
- STOP from any state: go to IDLE, clear BusBusy and AddrMatch, release SdaOe. A partial byte is discarded with no RxValid.
- ADDR: on each SclPos, shift SdaLevel in MSB first; 3-bit counter.
  - On the 8th sample, match = (byte[7:1]==SLAVE_ADDR) & (byte[0]==0).
  - On the next SclNeg: if match, go to ADDR_ACK and set SdaOe and AddrMatch; otherwise go to IGNORE.
- ADDR_ACK / DATA_ACK: SdaOe held through the ACK SCL high. On the next SclNeg, release SdaOe and go to DATA with the counter at 0.
- DATA: shift as in ADDR.
  - On the SclNeg after the 8th sample, load RxData and pulse RxValid for one cycle.
  - RxFirst = 1 for the first byte since address ACK, else 0.
  - Then set SdaOe and go to DATA_ACK. Every data byte is ACKed.
- IGNORE: SdaOe = 0; leave only on START or STOP.
- R/W=1 (read) is treated as a mismatch: the address is NACKed.

## Timing
- Reset values: SdaOe=0, RxData=8'h00, RxValid=0, RxFirst=0, BusBusy=0, AddrMatch=0; state IDLE, counter 0.
- All outputs are registered. Each output changes in the cycle after the qualifying input pulse (1 CLK latency):
  - SdaOe rises 1 cycle after SclNeg.
  - SdaOe falls 1 cycle after the next SclNeg.
  - RxValid is high exactly 1 cycle.
- RxData is stable from its RxValid until the next RxValid.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronous), including SdaOe during ACK. After release the block waits in IDLE for a START.
- Back-to-back bytes have no bubble requirement. The consumer must accept RxValid every 9 SCL periods.

## Configuration
- IIC_GENERAL_CALL_EN defined: address byte 8'h00 (general call, write) also matches. It is ACKed and its data bytes are received normally.
- IIC_GENERAL_CALL_EN undefined: 8'h00 is a mismatch and goes to IGNORE.

## Structure
- Package iic_pkg holds:
  - state encoding localparams (IDLE..IGNORE, 3 bits);
  - IIC_ADDR_W=7, IIC_BYTE_W=8;
  - GENERAL_CALL_ADDR=7'h00.
- One sub-module, iic_cond_detect: combinational START/STOP decode from SclLevel/SclPos/SdaPos/SdaNeg. The shift register, counter and FSM stay in the top.
- Edge detectors are instantiated in the parent, not here.

## Test plan
- START, addr 0xA0 (0x50 write), data 0xA5, STOP:
  - SdaOe pulses during both ACK clocks.
  - RxValid once with RxData=0xA5, RxFirst=1.
  - BusBusy 1→0 at STOP.
- START, addr 0xA2 (0x51): SdaOe stays 0, no RxValid, state IGNORE until STOP.
- START, addr 0xA1 (read): NACK (SdaOe 0), no RxValid.
- START, addr 0xA0, data 0x3C, 0x7E: two RxValid strobes, RxFirst 1 then 0. Then 4 bits of a third byte, then STOP: no third RxValid, IDLE.
- START, addr 0xA0, 3 data bits, repeated START, addr 0xA0, data 0x11: single RxValid, 0x11, RxFirst=1.
- RSTn low while SdaOe=1 during ACK: SdaOe=0 in the same cycle, all outputs at reset values.
- With IIC_GENERAL_CALL_EN: addr 0x00, data 0x06 → ACK, RxValid with 0x06.
- Without IIC_GENERAL_CALL_EN: same stimulus → NACK.
